// File: rtl/ipv4_header_checker.sv
// Parses an IPv4 header from a 32-bit beat stream and reports fields, checksum and error status.
// Latency: result valid the cycle after the final header beat (or the truncating TLAST beat).
// Backpressure: S_TREADY drops while a result waits for HDR_READY; payload beats are drained afterwards.
module ipv4_header_checker (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] S_TDATA,
    input  logic        S_TVALID,
    output logic        S_TREADY,
    input  logic        S_TLAST,
    output logic        HDR_VALID,
    input  logic        HDR_READY,
    output logic [7:0]  VERSION,
    output logic [7:0]  SERVICE_TYPE,
    output logic [15:0] LENGTH,
    output logic [15:0] IDENTIFICATION,
    output logic [15:0] FLAGS_AND_FRAGMENT,
    output logic [7:0]  TTL,
    output logic [7:0]  PROTOCOL,
    output logic [31:0] SRC_IP_ADDRESS,
    output logic [31:0] DST_IP_ADDRESS,
    output logic        CHECKSUM_OK,
    output logic        ERR_HEADER,
    output logic        ERR_TRUNCATED
);

    typedef enum logic [1:0] {
        ST_HDR    = 2'd0,
        ST_REPORT = 2'd1,
        ST_DRAIN  = 2'd2
    } state_t;

    state_t      state;
    logic [20:0] acc;
    logic [3:0]  beat_cnt;
    logic [3:0]  ihl_q;
    logic        pkt_done;

    logic        beat_xfer;
    logic [3:0]  hdr_ihl;
    logic [3:0]  eff_ihl;
    logic [20:0] acc_next;
    logic [16:0] fold1;
    logic [15:0] fold2;
    logic        is_last_hdr;

    // Handshake, effective header length and the running/folded checksum for the current beat
    always_comb begin
        S_TREADY    = !RESET && (state != ST_REPORT);
        beat_xfer   = S_TVALID && S_TREADY;
        // On beat 0 the length comes straight off the wire; later beats use the latched value
        hdr_ihl     = (beat_cnt == 4'd0) ? S_TDATA[27:24] : ihl_q;
        eff_ihl     = (hdr_ihl < 4'd5) ? 4'd5 : hdr_ihl;
        acc_next    = acc + {5'd0, S_TDATA[31:16]} + {5'd0, S_TDATA[15:0]};
        fold1       = {1'b0, acc_next[15:0]} + {12'd0, acc_next[20:16]};
        fold2       = fold1[15:0] + {15'd0, fold1[16]};
        is_last_hdr = (beat_cnt == (eff_ihl - 4'd1));
    end

    // Header parse / report / drain sequencer with registered results
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state              <= ST_HDR;
            acc                <= '0;
            beat_cnt           <= '0;
            ihl_q              <= '0;
            pkt_done           <= 1'b0;
            HDR_VALID          <= 1'b0;
            VERSION            <= '0;
            SERVICE_TYPE       <= '0;
            LENGTH             <= '0;
            IDENTIFICATION     <= '0;
            FLAGS_AND_FRAGMENT <= '0;
            TTL                <= '0;
            PROTOCOL           <= '0;
            SRC_IP_ADDRESS     <= '0;
            DST_IP_ADDRESS     <= '0;
            CHECKSUM_OK        <= 1'b0;
            ERR_HEADER         <= 1'b0;
            ERR_TRUNCATED      <= 1'b0;
        end else begin
            case (state)
                ST_HDR: begin
                    if (beat_xfer) begin
                        acc      <= acc_next;
                        beat_cnt <= beat_cnt + 4'd1;
                        case (beat_cnt)
                            4'd0: begin
                                VERSION      <= S_TDATA[31:24];
                                SERVICE_TYPE <= S_TDATA[23:16];
                                LENGTH       <= S_TDATA[15:0];
                                ihl_q        <= eff_ihl;
                                ERR_HEADER   <= (S_TDATA[31:28] != 4'd4) || (S_TDATA[27:24] < 4'd5);
                            end
                            4'd1: begin
                                IDENTIFICATION     <= S_TDATA[31:16];
                                FLAGS_AND_FRAGMENT <= S_TDATA[15:0];
                            end
                            4'd2: begin
                                TTL      <= S_TDATA[31:24];
                                PROTOCOL <= S_TDATA[23:16];
                            end
                            4'd3: SRC_IP_ADDRESS <= S_TDATA;
                            4'd4: DST_IP_ADDRESS <= S_TDATA;
                            default: ;
                        endcase
                        if (is_last_hdr) begin
                            state       <= ST_REPORT;
                            HDR_VALID   <= 1'b1;
                            CHECKSUM_OK <= (fold2 == 16'hFFFF);
                            pkt_done    <= S_TLAST;
                        end else if (S_TLAST) begin
                            state         <= ST_REPORT;
                            HDR_VALID     <= 1'b1;
                            CHECKSUM_OK   <= 1'b0;
                            ERR_TRUNCATED <= 1'b1;
                            pkt_done      <= 1'b1;
                        end
                    end
                end
                ST_REPORT: begin
                    if (HDR_READY) begin
                        // Result consumed: wipe per-packet state so the next packet starts clean
                        HDR_VALID          <= 1'b0;
                        state              <= pkt_done ? ST_HDR : ST_DRAIN;
                        acc                <= '0;
                        beat_cnt           <= '0;
                        ihl_q              <= '0;
                        pkt_done           <= 1'b0;
                        VERSION            <= '0;
                        SERVICE_TYPE       <= '0;
                        LENGTH             <= '0;
                        IDENTIFICATION     <= '0;
                        FLAGS_AND_FRAGMENT <= '0;
                        TTL                <= '0;
                        PROTOCOL           <= '0;
                        SRC_IP_ADDRESS     <= '0;
                        DST_IP_ADDRESS     <= '0;
                        CHECKSUM_OK        <= 1'b0;
                        ERR_HEADER         <= 1'b0;
                        ERR_TRUNCATED      <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    if (beat_xfer && S_TLAST) begin
                        state    <= ST_HDR;
                        acc      <= '0;
                        beat_cnt <= '0;
                    end
                end
                default: state <= ST_HDR;
            endcase
        end
    end

endmodule

// File: tb/tb_ipv4_header_checker.sv
// Directed bench for ipv4_header_checker with a field/checksum reference model and per-cycle compare.
// Latency: expects HDR_VALID the cycle after the header-ending beat.
// Backpressure: exercises HDR_READY stalls, payload drain and back-to-back packets.
module tb_ipv4_header_checker;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic [31:0] S_TDATA = '0;
    logic        S_TVALID = 1'b0;
    logic        S_TREADY;
    logic        S_TLAST = 1'b0;
    logic        HDR_VALID;
    logic        HDR_READY = 1'b1;
    logic [7:0]  VERSION, SERVICE_TYPE, TTL, PROTOCOL;
    logic [15:0] LENGTH, IDENTIFICATION, FLAGS_AND_FRAGMENT;
    logic [31:0] SRC_IP_ADDRESS, DST_IP_ADDRESS;
    logic        CHECKSUM_OK, ERR_HEADER, ERR_TRUNCATED;

    ipv4_header_checker dut (
        .CLK(CLK), .RESET(RESET), .S_TDATA(S_TDATA), .S_TVALID(S_TVALID), .S_TREADY(S_TREADY),
        .S_TLAST(S_TLAST), .HDR_VALID(HDR_VALID), .HDR_READY(HDR_READY),
        .VERSION(VERSION), .SERVICE_TYPE(SERVICE_TYPE), .LENGTH(LENGTH),
        .IDENTIFICATION(IDENTIFICATION), .FLAGS_AND_FRAGMENT(FLAGS_AND_FRAGMENT),
        .TTL(TTL), .PROTOCOL(PROTOCOL), .SRC_IP_ADDRESS(SRC_IP_ADDRESS),
        .DST_IP_ADDRESS(DST_IP_ADDRESS), .CHECKSUM_OK(CHECKSUM_OK),
        .ERR_HEADER(ERR_HEADER), .ERR_TRUNCATED(ERR_TRUNCATED)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [7:0]  version;
        logic [7:0]  service;
        logic [15:0] length;
        logic [15:0] ident;
        logic [15:0] flags;
        logic [7:0]  ttl;
        logic [7:0]  proto;
        logic [31:0] src;
        logic [31:0] dst;
        logic        ok;
        logic        errh;
        logic        errt;
    } res_t;

    int          vectors = 0;
    int          miscompares = 0;
    int          pushes = 0;
    int          handshakes = 0;
    int          first_wait = 0;
    logic [31:0] pkt [0:15];
    res_t        exp_q [$];
    res_t        r;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: what a receiver must report for the first n words of pkt, TLAST on word n-1
    function automatic res_t model(input int n);
        res_t        m;
        int          ihl, eff, hb, s;
        logic [31:0] w [0:4];
        ihl = int'(pkt[0][27:24]);
        eff = (ihl < 5) ? 5 : ihl;
        hb  = (n < eff) ? n : eff;
        for (int i = 0; i < 5; i++) w[i] = (i < hb) ? pkt[i] : 32'h0;
        s = 0;
        for (int i = 0; i < hb; i++) begin
            s = s + int'(pkt[i][31:16]);
            s = (s & 'hFFFF) + (s >> 16);
            s = s + int'(pkt[i][15:0]);
            s = (s & 'hFFFF) + (s >> 16);
        end
        m.version = w[0][31:24];
        m.service = w[0][23:16];
        m.length  = w[0][15:0];
        m.ident   = w[1][31:16];
        m.flags   = w[1][15:0];
        m.ttl     = w[2][31:24];
        m.proto   = w[2][23:16];
        m.src     = w[3];
        m.dst     = w[4];
        m.errt    = (n < eff);
        m.ok      = (s == 'hFFFF) && !m.errt;
        m.errh    = (pkt[0][31:28] != 4'd4) || (ihl < 5);
        return m;
    endfunction

    // Every cycle a result is presented it must match the oldest outstanding expectation
    always @(negedge CLK) begin
        res_t act;
        if (!RESET && HDR_VALID) begin
            act = '{VERSION, SERVICE_TYPE, LENGTH, IDENTIFICATION, FLAGS_AND_FRAGMENT,
                    TTL, PROTOCOL, SRC_IP_ADDRESS, DST_IP_ADDRESS,
                    CHECKSUM_OK, ERR_HEADER, ERR_TRUNCATED};
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_hdr_valid: got result %h expected none", act);
            end else begin
                if (act !== exp_q[0]) begin
                    miscompares++;
                    $display("FAIL result: got %h expected %h", act, exp_q[0]);
                end
                if (HDR_READY) begin
                    void'(exp_q.pop_front());
                    handshakes++;
                end
            end
            chk("tready_in_report", {31'd0, S_TREADY}, 32'd0);
        end
    end

    // Drive n words of pkt starting at posedge+1; optionally register the expected result
    task automatic send(input int n, input bit last, input bit push);
        bit rdy;
        bit pend;
        int waits;
        int ihl, eff, hend;
        ihl  = int'(pkt[0][27:24]);
        eff  = (ihl < 5) ? 5 : ihl;
        hend = (n < eff) ? n - 1 : eff - 1;
        pend = 1'b0;
        if (push) begin
            exp_q.push_back(model(n));
            pushes++;
        end
        for (int i = 0; i < n; i++) begin
            S_TDATA  = pkt[i];
            S_TVALID = 1'b1;
            S_TLAST  = last && (i == n - 1);
            waits    = 0;
            forever begin
                @(negedge CLK);
                if (pend) begin
                    chk("hdr_valid_latency", {31'd0, HDR_VALID}, 32'd1);
                    pend = 1'b0;
                end
                rdy = S_TREADY;
                @(posedge CLK);
                #1;
                if (rdy) break;
                waits++;
                if (waits > 200) begin
                    chk("beat_accept_timeout", 32'd0, 32'd1);
                    break;
                end
            end
            if (i == 0) first_wait = waits;
            if (push && i == hend) pend = 1'b1;
        end
        S_TVALID = 1'b0;
        S_TLAST  = 1'b0;
        if (pend) begin
            @(negedge CLK);
            chk("hdr_valid_latency", {31'd0, HDR_VALID}, 32'd1);
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic do_reset();
        @(posedge CLK);
        #1;
        RESET    = 1'b1;
        S_TVALID = 1'b0;
        @(negedge CLK);
        chk("reset_tready", {31'd0, S_TREADY}, 32'd0);
        @(posedge CLK);
        #1;
        @(negedge CLK);
        chk("reset_hdr_valid", {31'd0, HDR_VALID}, 32'd0);
        chk("reset_src", SRC_IP_ADDRESS, 32'd0);
        chk("reset_flags", {29'd0, CHECKSUM_OK, ERR_HEADER, ERR_TRUNCATED}, 32'd0);
        chk("reset_length", {16'd0, LENGTH}, 32'd0);
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        @(negedge CLK);
        chk("post_reset_tready", {31'd0, S_TREADY}, 32'd1);
        @(posedge CLK);
        #1;
    endtask

    task automatic load_basic();
        pkt[0] = 32'h45000073; pkt[1] = 32'h00004000; pkt[2] = 32'h4011B861;
        pkt[3] = 32'hC0A80001; pkt[4] = 32'hC0A800C7;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();

        // Basic good header, pinned against hand-computed values
        load_basic();
        r = model(5);
        chk("model_basic_ok", {31'd0, r.ok}, 32'd1);
        chk("model_basic_len", {16'd0, r.length}, 32'h0073);
        chk("model_basic_ttl_proto", {16'd0, r.ttl, r.proto}, 32'h4011);
        chk("model_basic_src", r.src, 32'hC0A80001);
        chk("model_basic_dst", r.dst, 32'hC0A800C7);
        send(5, 1'b1, 1'b1);

        // Corrupted checksum
        load_basic();
        pkt[2] = 32'h4011B862;
        r = model(5);
        chk("model_badsum_ok", {29'd0, r.ok, r.errh, r.errt}, 32'd0);
        send(5, 1'b1, 1'b1);

        // IHL=6 with one option word and three payload beats
        pkt[0] = 32'h46000073; pkt[1] = 32'h00004000; pkt[2] = 32'h4011B761;
        pkt[3] = 32'hC0A80001; pkt[4] = 32'hC0A800C7; pkt[5] = 32'h00000000;
        pkt[6] = 32'hDEADBEEF; pkt[7] = 32'h12345678; pkt[8] = 32'hFFFFFFFF;
        r = model(9);
        chk("model_ihl6_ok", {31'd0, r.ok}, 32'd1);
        send(9, 1'b1, 1'b1);
        // Next packet must be accepted without an idle cycle after the drain
        load_basic();
        send(5, 1'b1, 1'b1);
        chk("drain_to_hdr_no_idle", first_wait, 32'd0);

        // Truncated after beat 2
        load_basic();
        r = model(3);
        chk("model_trunc_flags", {29'd0, r.ok, r.errh, r.errt}, 32'd1);
        chk("model_trunc_src", r.src, 32'd0);
        send(3, 1'b1, 1'b1);

        // Header error: IHL<5 (treated as 5) and a bad version
        load_basic();
        pkt[0] = 32'h44000073;
        r = model(5);
        chk("model_short_ihl_errh", {31'd0, r.errh}, 32'd1);
        send(5, 1'b1, 1'b1);
        load_basic();
        pkt[0] = 32'h65000073;
        send(5, 1'b1, 1'b1);

        // Header followed by payload that must be drained, TLAST on the final header beat absent
        load_basic();
        pkt[5] = 32'hAAAA5555; pkt[6] = 32'h0BADF00D;
        send(7, 1'b1, 1'b1);

        // Result held under backpressure while junk beats are offered
        load_basic();
        HDR_READY = 1'b0;
        send(5, 1'b1, 1'b1);
        for (int k = 0; k < 4; k++) begin
            S_TVALID = 1'b1;
            S_TDATA  = $urandom;
            @(negedge CLK);
            chk("hold_hdr_valid", {31'd0, HDR_VALID}, 32'd1);
            @(posedge CLK);
            #1;
        end
        S_TVALID  = 1'b0;
        HDR_READY = 1'b1;
        @(negedge CLK);
        chk("hold_release_valid", {31'd0, HDR_VALID}, 32'd1);
        @(posedge CLK);
        #1;
        @(negedge CLK);
        chk("after_handshake_valid", {31'd0, HDR_VALID}, 32'd0);
        @(posedge CLK);
        #1;

        // Reset mid-header abandons the packet; the next full packet reports once
        load_basic();
        send(3, 1'b0, 1'b0);
        do_reset();
        load_basic();
        send(5, 1'b1, 1'b1);

        repeat (4) @(posedge CLK);
        @(negedge CLK);
        chk("all_results_seen", handshakes, pushes);
        chk("queue_empty", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ipv4_header_checker.md
IPV4_HEADER_CHECKER -- requirements
Module: ipv4_header_checker

Interface
REQ-001 SHALL have port CLK, input, 1, single clock; all logic on its rising edge.
REQ-002 SHALL have port RESET, input, 1, synchronous active-high reset.
REQ-003 SHALL have port S_TDATA, input, 32, header/packet beat, big-endian (first wire byte in [31:24]).
REQ-004 SHALL have ports S_TVALID input 1, S_TREADY output 1, S_TLAST input 1; a beat transfers when S_TVALID and S_TREADY are both high on a rising edge.
REQ-005 SHALL have ports HDR_VALID output 1 and HDR_READY input 1; a result transfers when both are high.
REQ-006 SHALL have result outputs (registered):
- VERSION 8 (version+IHL byte)
- SERVICE_TYPE 8
- LENGTH 16
- IDENTIFICATION 16
- FLAGS_AND_FRAGMENT 16
- TTL 8
- PROTOCOL 8
- SRC_IP_ADDRESS 32
- DST_IP_ADDRESS 32
REQ-007 SHALL have status outputs, 1 bit each: CHECKSUM_OK, ERR_HEADER (version!=4 or IHL<5), ERR_TRUNCATED (S_TLAST before header end).

Function
REQ-008 SHALL implement states HDR, REPORT, DRAIN; S_TREADY=1 in HDR and DRAIN, 0 in REPORT.
REQ-009 In HDR, SHALL count accepted beats 0..14 and latch field words:
- beat 0 -> VERSION/SERVICE_TYPE/LENGTH
- beat 1 -> IDENTIFICATION/FLAGS_AND_FRAGMENT
- beat 2 -> TTL/PROTOCOL (checksum half not output)
- beat 3 -> SRC_IP_ADDRESS
- beat 4 -> DST_IP_ADDRESS
- beats 5..IHL-1 (options) -> summed only, not stored
REQ-010 SHALL add S_TDATA[31:16] and S_TDATA[15:0] into a 21-bit accumulator per accepted header beat (30 x 0xFFFF max, no overflow).
REQ-011 Header length SHALL be IHL = beat-0 S_TDATA[27:24] words; if IHL<5, SHALL use 5 and set ERR_HEADER.
REQ-012 Checksum check SHALL fold twice: f1 = acc[15:0] + acc[20:16]; f2 = f1[15:0] + f1[16]; CHECKSUM_OK = (f2 == 16'hFFFF) and not ERR_TRUNCATED.
REQ-013 On acceptance of beat IHL-1, SHALL go to REPORT; HDR_VALID SHALL assert the next cycle with all results stable.
REQ-014 Results and HDR_VALID SHALL hold unchanged while HDR_VALID=1 and HDR_READY=0.
REQ-015 On the REPORT handshake, SHALL go to HDR if the final header beat carried S_TLAST (or truncation occurred), else to DRAIN; HDR_VALID SHALL deassert the next cycle.
REQ-016 DRAIN SHALL discard beats until one with S_TLAST is accepted, then go to HDR with accumulator and beat count cleared.
REQ-017 S_TLAST on a header beat before beat IHL-1 SHALL set ERR_TRUNCATED, clear CHECKSUM_OK, and go to REPORT; unreceived fields SHALL read 0.
REQ-018 S_TLAST on beat IHL-1 itself SHALL NOT be truncation.
REQ-019 Accumulator, beat count and status flags SHALL clear on entry to HDR so consecutive packets are independent; back-to-back packets SHALL need no idle cycle in DRAIN->HDR.
REQ-020 Beats SHALL NOT be accepted in REPORT; S_TVALID/S_TDATA changes there SHALL have no effect.

Reset
REQ-021 RESET high SHALL force state HDR, accumulator and beat count 0, HDR_VALID 0, all result and status outputs 0, and S_TREADY 0 during the reset cycle.
REQ-022 RESET asserted mid-header, in REPORT or in DRAIN SHALL abandon the packet; no HDR_VALID for it; S_TREADY=1 the first cycle after RESET falls.

Verification
REQ-023 5 beats 45000073, 00004000, 4011B861, C0A80001, C0A800C7 (TLAST on last), HDR_READY=1 -> HDR_VALID one cycle after beat 4; CHECKSUM_OK=1; LENGTH=0073; TTL=40; PROTOCOL=11; SRC=C0A80001; DST=C0A800C7; state returns to HDR.
REQ-024 Same header with beat 2 = 4011B862 -> CHECKSUM_OK=0, ERR flags 0.
REQ-025 IHL=6: beats 46000073, 00004000, 4011B761, C0A80001, C0A800C7, 00000000, then 3 payload beats, TLAST on the 3rd -> HDR_VALID after beat 5; CHECKSUM_OK=1; payload drained; next packet accepted on the following cycle.
REQ-026 First 3 beats of the REQ-023 header, TLAST on beat 2 -> ERR_TRUNCATED=1, CHECKSUM_OK=0, SRC/DST=0.
REQ-027 REQ-023 header with HDR_READY low 5 cycles -> HDR_VALID and all fields stable, S_TREADY=0 throughout; releases one cycle after handshake.
REQ-028 RESET pulsed after beat 2 of a packet, then a full REQ-023 packet -> exactly one HDR_VALID, CHECKSUM_OK=1.
